// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU demo types and constants
//
// Purpose: common definitions for the sequential multiplier and its adder.
//   MUL_WIDTH   : operand/result width (the adder is fixed at 32 bits)
//   CNT_W       : iteration counter width
//   mul_state_t : multiplier FSM states
package alu_pkg;

    localparam int MUL_WIDTH = 32;
    localparam int CNT_W     = $clog2(MUL_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/mul_seq_add.sv
// rtl/mul_seq_add.sv - 32-bit combinational adder used by the multiplier
//
// Purpose: sum = a + b, carry out of bit 31 discarded.
// Ports:
//   a   in  32  addend
//   b   in  32  addend
//   sum out 32  (a + b) mod 2^32
module Add (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - iterative radix-2 shift-add unsigned multiplier
//
// Purpose: returns the low WIDTH bits of a*b, one multiplier bit per clock.
// Ports:
//   clk       in  1      rising-edge clock
//   rst       in  1      asynchronous active-high reset
//   in_valid  in  1      operand pair valid
//   in_ready  out 1      block can accept operands (IDLE only)
//   a         in  WIDTH  multiplicand
//   b         in  WIDTH  multiplier
//   out_valid out 1      product valid (DONE)
//   out_ready in  1      consumer accepts product
//   product   out WIDTH  (a*b) mod 2^WIDTH, held until the output handshake
//   busy      out 1      high in RUN or DONE
module mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH      = MUL_WIDTH,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] product,
    output logic             busy
);

    mul_state_t       state;
    mul_state_t       state_nxt;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] add_sum;
    logic [WIDTH-1:0] acc_nxt;
    logic             accept;
    logic             zero_b;
    logic             run_last;

    Add u_add (
        .a   (acc),
        .b   (mcand),
        .sum (add_sum)
    );

    assign acc_nxt = mplier[0] ? add_sum : acc;
    assign accept  = in_valid & in_ready;
    assign zero_b  = EARLY_EXIT && (b == '0);

    // Last iteration: full count reached, or (early exit) no set bits left
    // after this shift.
    assign run_last = (cnt == CNT_W'(WIDTH - 1)) ||
                      (EARLY_EXIT && (mplier[WIDTH-1:1] == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = zero_b ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (run_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // product is loaded with the final accumulator value on the edge that
    // enters DONE, so it is stable for the whole DONE period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mcand  <= a;
                        mplier <= b;
                        acc    <= '0;
                        cnt    <= '0;
                        if (zero_b) begin
                            product <= '0;
                        end
                    end
                end
                RUN: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (run_last) begin
                        product <= acc_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq.sv
// tb/tb_mul_seq.sv - self-checking bench for mul_seq
module tb_mul_seq;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_ready;

    logic        in_valid1, in_ready1, out_valid1, busy1;
    logic [31:0] product1;
    logic        in_valid0, in_ready0, out_valid0, busy0;
    logic [31:0] product0;

    int checks;
    int failures;

    mul_seq #(.WIDTH(32), .EARLY_EXIT(1'b1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a),
        .b         (b),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .product   (product1),
        .busy      (busy1)
    );

    mul_seq #(.WIDTH(32), .EARLY_EXIT(1'b0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid0),
        .in_ready  (in_ready0),
        .a         (a),
        .b         (b),
        .out_valid (out_valid0),
        .out_ready (out_ready),
        .product   (product0),
        .busy      (busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          ee;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] p;
        int          k;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic sel_ready(input bit ee);
        return ee ? in_ready1 : in_ready0;
    endfunction
    function automatic logic sel_valid(input bit ee);
        return ee ? out_valid1 : out_valid0;
    endfunction
    function automatic logic sel_busy(input bit ee);
        return ee ? busy1 : busy0;
    endfunction
    function automatic logic [31:0] sel_prod(input bit ee);
        return ee ? product1 : product0;
    endfunction

    // Drives one operation from a negedge; returns number of rising edges
    // after the accepting edge until out_valid is seen (k), bounded.
    task automatic start_op(input bit ee, input logic [31:0] av, input logic [31:0] bv);
        a = av;
        b = bv;
        if (ee) in_valid1 = 1'b1; else in_valid0 = 1'b1;
        check("in_ready_before_accept", {31'd0, sel_ready(ee)}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid1 = 1'b0;
        in_valid0 = 1'b0;
    endtask

    task automatic wait_done(input bit ee, output int k);
        k = 0;
        while (!sel_valid(ee) && k < 100) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic finish_op(input bit ee);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("out_valid_after_handshake", {31'd0, sel_valid(ee)}, 32'd0);
        check("in_ready_after_handshake", {31'd0, sel_ready(ee)}, 32'd1);
    endtask

    initial begin
        int k;
        int pulses;
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        in_valid1 = 1'b0;
        in_valid0 = 1'b0;

        vecs[0] = '{1'b1, 32'd3,        32'd5,        32'd15,       3};
        vecs[1] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32};
        vecs[2] = '{1'b1, 32'h00010000, 32'h00010000, 32'h00000000, 17};
        vecs[3] = '{1'b1, 32'd7,        32'd0,        32'd0,        0};
        vecs[4] = '{1'b0, 32'd9,        32'd1,        32'd9,        32};
        vecs[5] = '{1'b0, 32'd3,        32'd5,        32'd15,       32};
        vecs[6] = '{1'b1, 32'h12345678, 32'd1,        32'h12345678, 1};
        vecs[7] = '{1'b1, 32'd1,        32'h80000000, 32'h80000000, 32};

        #1;
        check("rst_in_ready1", {31'd0, in_ready1}, 32'd1);
        check("rst_out_valid1", {31'd0, out_valid1}, 32'd0);
        check("rst_busy1", {31'd0, busy1}, 32'd0);
        check("rst_product1", product1, 32'd0);
        check("rst_product0", product0, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            start_op(vecs[i].ee, vecs[i].a, vecs[i].b);
            wait_done(vecs[i].ee, k);
            check($sformatf("vec%0d_latency", i), k, vecs[i].k);
            check($sformatf("vec%0d_product", i), sel_prod(vecs[i].ee), vecs[i].p);
            check($sformatf("vec%0d_busy", i), {31'd0, sel_busy(vecs[i].ee)}, 32'd1);
            finish_op(vecs[i].ee);
        end

        // Output back-pressure with stray in_valid pulses.
        out_ready = 1'b0;
        start_op(1'b1, 32'd6, 32'd7);
        wait_done(1'b1, k);
        check("hold_latency", k, 3);
        for (int c = 0; c < 5; c++) begin
            a = 32'd100 + c;
            b = 32'd3;
            in_valid1 = c[0];
            @(negedge clk);
            check("hold_product", product1, 32'd42);
            check("hold_out_valid", {31'd0, out_valid1}, 32'd1);
            check("hold_in_ready", {31'd0, in_ready1}, 32'd0);
        end
        in_valid1 = 1'b0;
        finish_op(1'b1);
        check("hold_product_kept", product1, 32'd42);

        // Reset during RUN drops the operation.
        start_op(1'b0, 32'd9, 32'd1);
        @(negedge clk);
        check("mid_run_busy", {31'd0, busy0}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_run_in_ready", {31'd0, in_ready0}, 32'd1);
        check("rst_mid_run_busy", {31'd0, busy0}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid0) pulses++;
        end
        check("rst_no_out_valid", pulses, 0);
        start_op(1'b0, 32'd2, 32'd3);
        wait_done(1'b0, k);
        check("post_rst_latency", k, 32);
        check("post_rst_product", product0, 32'd6);
        finish_op(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
